// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with PC, imem req/ack port, redirect handling and IF/ID register
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target sends the PC to TRAP_PC and pulses if_misalign
//   undefined : redirect targets are forced word aligned, if_misalign stays 0
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   stall       in   hazard stall, freezes PC, IF/ID and the skid word
//   pc_src      in   00 seq, 01 branch, 10 jump, 11 jump-register
//   branch      in   branch target from ID
//   offset28    in   jump offset from ID, already shifted left by 2
//   jr_target   in   forwarded rs value for jr
//   imem_req    out  fetch request (registered)
//   imem_addr   out  fetch address (the PC)
//   imem_rdata  in   instruction word, valid with imem_ack
//   imem_ack    in   one-cycle completion of the current request
//   pc_4_out    out  IF/ID: fetched instruction address + 4
//   ins_out     out  IF/ID: instruction word
//   ins_valid   out  IF/ID: 1 real instruction, 0 bubble
//   if_misalign out  one-cycle pulse on a misaligned redirect target
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch,
    input  logic [27:0] offset28,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc_4_out,
    output logic [31:0] ins_out,
    output logic        ins_valid,
    output logic        if_misalign
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HELD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_skid;
    logic        r_req;
    logic [31:0] r_pc_4;
    logic [31:0] r_ins;
    logic        r_valid;
    logic        r_misalign;

    logic [31:0] w_pc_4;
    logic        w_redir;
    logic [31:0] w_raw;
    logic        w_bad;
    logic [31:0] w_target;

    always_comb begin
        w_pc_4  = r_pc + 32'd4;
        w_redir = (pc_src != 2'b00) && !stall;
        w_raw   = pc_src == 2'b01 ? branch :
                  pc_src == 2'b10 ? {r_pc_4[31:28], offset28} : jr_target;
`ifdef IF_MISALIGN_TRAP_EN
        w_bad   = w_raw[1:0] != 2'b00;
`else
        w_bad   = 1'b0;
`endif
        // w_bad only rises with the trap feature; otherwise the low bits are simply cleared
        w_target = w_bad ? TRAP_PC : (w_raw & ~32'd3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_pend_pc  <= RESET_PC;
            r_skid     <= NOP_INS;
            r_req      <= 1'b0;
            r_pc_4     <= 32'd0;
            r_ins      <= NOP_INS;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_bad && w_redir && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    r_req   <= 1'b1;
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        if (w_redir) begin
                            // returned word is on the wrong path
                            r_ins   <= NOP_INS;
                            r_valid <= 1'b0;
                            r_pc    <= w_target;
                        end else if (stall) begin
                            // park the word until the stall lifts; no new request meanwhile
                            r_skid  <= imem_rdata;
                            r_req   <= 1'b0;
                            r_state <= HELD;
                        end else begin
                            r_pc_4  <= w_pc_4;
                            r_ins   <= imem_rdata;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_4;
                        end
                    end else begin
                        // request cannot be abandoned: remember target and wait it out
                        if (w_redir) begin
                            r_pend_pc <= w_target;
                            r_state   <= DRAIN;
                        end
                        if (!stall) begin
                            r_ins   <= NOP_INS;
                            r_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        r_ins   <= NOP_INS;
                        r_valid <= 1'b0;
                    end
                    if (imem_ack) begin
                        r_pc    <= w_redir ? w_target : r_pend_pc;
                        r_state <= FETCH;
                    end else if (w_redir) begin
                        r_pend_pc <= w_target;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        r_req   <= 1'b1;
                        r_state <= FETCH;
                        if (w_redir) begin
                            r_ins   <= NOP_INS;
                            r_valid <= 1'b0;
                            r_pc    <= w_target;
                        end else begin
                            r_pc_4  <= w_pc_4;
                            r_ins   <= r_skid;
                            r_valid <= 1'b1;
                            r_pc    <= w_pc_4;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc_4_out    = r_pc_4;
    assign ins_out     = r_ins;
    assign ins_valid   = r_valid;
    assign if_misalign = r_misalign;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a wait-state instruction memory model
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch = 32'd0;
    logic [27:0] offset28 = 28'd0;
    logic [31:0] jr_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] pc_4_out;
    logic [31:0] ins_out;
    logic        ins_valid;
    logic        if_misalign;

    int n_chk = 0;
    int n_err = 0;
    int wait_n = 0;
    int cnt;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src), .branch(branch),
        .offset28(offset28), .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc_4_out(pc_4_out), .ins_out(ins_out),
        .ins_valid(ins_valid), .if_misalign(if_misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
    endfunction

    // memory: acks once the request has waited wait_n cycles, resets with the DUT
    assign imem_rdata = mem(imem_addr);
    assign imem_ack   = imem_req && (cnt >= wait_n);
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (imem_ack) cnt <= 0;
        else if (imem_req) cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // leaves the bench just after the first request has been raised
    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        pc_src = 2'b00;
        wait_n = 0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    logic [31:0] exp_jr;
    logic        exp_mis;

    initial begin
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc4", pc_4_out, 32'h0);
        chk("rst_ins", ins_out, 32'h0);
        chk("rst_valid", ins_valid, 0);
        chk("rst_mis", if_misalign, 0);

        // sustained fetch with zero wait states
        do_reset();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_valid0", ins_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_ins", ins_out, mem(32'(4 * i)));
            chk("t1_pc4", pc_4_out, 32'(4 * i + 4));
            chk("t1_valid", ins_valid, 1);
        end

        // three wait states on address 8
        do_reset();
        tick();
        tick();
        wait_n = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_bubble", ins_valid, 0);
            chk("t2_addr", imem_addr, 32'h8);
        end
        tick();
        chk("t2_ins", ins_out, mem(32'h8));
        chk("t2_pc4", pc_4_out, 32'hC);
        chk("t2_valid", ins_valid, 1);
        wait_n = 0;

        // two-cycle stall on the ack of address 4
        do_reset();
        tick();
        stall = 1'b1;
        tick();
        chk("t3_req0", imem_req, 0);
        chk("t3_hold_ins", ins_out, mem(32'h0));
        chk("t3_hold_pc4", pc_4_out, 32'h4);
        chk("t3_hold_addr", imem_addr, 32'h4);
        tick();
        chk("t3_req0b", imem_req, 0);
        chk("t3_hold_ins2", ins_out, mem(32'h0));
        stall = 1'b0;
        tick();
        chk("t3_ins", ins_out, mem(32'h4));
        chk("t3_pc4", pc_4_out, 32'h8);
        chk("t3_addr", imem_addr, 32'h8);
        chk("t3_req1", imem_req, 1);
        tick();
        chk("t3_next", ins_out, mem(32'h8));

        // branch with ack
        do_reset();
        tick();
        tick();
        pc_src = 2'b01;
        branch = 32'h40;
        tick();
        chk("t4_bubble", ins_valid, 0);
        chk("t4_addr", imem_addr, 32'h40);
        pc_src = 2'b00;
        tick();
        chk("t4_ins", ins_out, mem(32'h40));
        chk("t4_pc4", pc_4_out, 32'h44);
        chk("t4_valid", ins_valid, 1);

        // jump while the fetch is still pending: drain then redirect
        do_reset();
        tick();
        pc_src = 2'b01;
        branch = 32'h1000_000C;
        tick();
        pc_src = 2'b00;
        tick();
        chk("t5_pc4", pc_4_out, 32'h1000_0010);
        wait_n = 2;
        pc_src = 2'b10;
        offset28 = 28'h000_0200;
        tick();
        chk("t5_bubble", ins_valid, 0);
        chk("t5_old_addr", imem_addr, 32'h1000_0010);
        chk("t5_req", imem_req, 1);
        pc_src = 2'b00;
        tick();
        chk("t5_old_addr2", imem_addr, 32'h1000_0010);
        tick();
        chk("t5_new_addr", imem_addr, 32'h1000_0200);
        chk("t5_discard", ins_valid, 0);
        wait_n = 0;
        tick();
        chk("t5_ins", ins_out, mem(32'h1000_0200));
        chk("t5_pc4b", pc_4_out, 32'h1000_0204);

        // misaligned jr target
`ifdef IF_MISALIGN_TRAP_EN
        exp_jr = 32'h80;
        exp_mis = 1'b1;
`else
        exp_jr = 32'h100;
        exp_mis = 1'b0;
`endif
        do_reset();
        tick();
        pc_src = 2'b11;
        jr_target = 32'h0000_0102;
        tick();
        chk("t6_addr", imem_addr, exp_jr);
        chk("t6_mis", if_misalign, 32'(exp_mis));
        pc_src = 2'b00;
        tick();
        chk("t6_mis_end", if_misalign, 0);
        chk("t6_ins", ins_out, mem(exp_jr));
        chk("t6_pc4", pc_4_out, exp_jr + 32'd4);

        // redirect on leaving HELD drops the skid word
        do_reset();
        tick();
        stall = 1'b1;
        tick();
        chk("t7_req0", imem_req, 0);
        stall = 1'b0;
        pc_src = 2'b01;
        branch = 32'h20;
        tick();
        chk("t7_bubble", ins_valid, 0);
        chk("t7_addr", imem_addr, 32'h20);
        chk("t7_req1", imem_req, 1);
        pc_src = 2'b00;
        tick();
        chk("t7_ins", ins_out, mem(32'h20));
        chk("t7_pc4", pc_4_out, 32'h24);

        // redirect is ignored while stalled
        do_reset();
        tick();
        stall = 1'b1;
        pc_src = 2'b01;
        branch = 32'h60;
        tick();
        chk("t8_hold_ins", ins_out, mem(32'h0));
        chk("t8_addr", imem_addr, 32'h4);
        stall = 1'b0;
        pc_src = 2'b00;
        tick();
        chk("t8_ins", ins_out, mem(32'h4));
        chk("t8_pc4", pc_4_out, 32'h8);

        // reset in the middle of an outstanding request
        do_reset();
        wait_n = 5;
        tick();
        tick();
        chk("t9_pending", imem_req, 1);
        reset = 1'b0;
        #1;
        chk("t9_req", imem_req, 0);
        chk("t9_valid", ins_valid, 0);
        chk("t9_addr", imem_addr, 32'h0);
        do_reset();
        tick();
        chk("t9_ins", ins_out, mem(32'h0));
        chk("t9_pc4", pc_4_out, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
